seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_pkg.sv | 19 +
 rtl/seg7_decode.sv | 18 +
 rtl/seg_scan_mux.sv | 199 +++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the 7-segment scanner.
// Holds the scan FSM state type, the BCD segment table and the blank code.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for digits 0..9.
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD-to-7-segment decoder (active-high).
// Codes 10..15 are not decimal digits and decode to all segments off.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // Table lookup for decimal codes, blank for anything else.
    always_comb begin
        seg = SEG_BLANK;
        if (code < 4'd10) begin
            seg = SEG_TABLE[code];
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed BCD-to-7-segment scanner.
// Scans N_DIGITS digits over a shared segment bus with an optional all-off gap
// between digits, leading-zero blanking and per-digit blink.
// Optional feature macro: SEG_SCAN_DP_EN adds dp_in/dp decimal-point support.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*N_DIGITS-1:0]   bcd_in,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic                    lzb_en,
`ifdef SEG_SCAN_DP_EN
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic                    dp,
`endif
    output logic [6:0]              seg,
    output logic [N_DIGITS-1:0]     dig_sel,
    output logic                    frame_done
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam int BW      = $clog2(BLINK_FRAMES) + 1;
    localparam int IW      = $clog2(N_DIGITS - 1) + 1;

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    // With no gap configured, every digit hand-off goes straight to SHOW.
    localparam state_t AFTER_DIGIT = (BLANK_CYCLES == 0) ? ST_SHOW : ST_GAP;

    localparam logic                POL     = (ACTIVE_LOW != 0);
    localparam logic [6:0]          SEG_OFF = {7{POL}};
    localparam logic [N_DIGITS-1:0] DIG_OFF = {N_DIGITS{POL}};

    state_t                 state, state_d;
    logic [IW-1:0]          idx, idx_d;
    logic [CW-1:0]          cnt, cnt_d;
    logic [4*N_DIGITS-1:0]  shadow, shadow_d;
    logic [BW-1:0]          bcnt, bcnt_d;
    logic                   phase, phase_d;
    logic                   frame_end;

    logic                   show;
    logic [N_DIGITS-1:0]    onehot;
    logic [4*N_DIGITS-1:0]  upper;
    logic [3:0]             digit_code;
    logic [6:0]             dec_seg;
    logic                   lzb_hit;
    logic                   blink_hit;
    logic [6:0]             seg_n;
    logic [N_DIGITS-1:0]    dig_n;

    // Next-state logic: scan sequencing, frame-boundary sampling and blink count.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        cnt_d     = cnt;
        shadow_d  = shadow;
        bcnt_d    = bcnt;
        phase_d   = phase;
        frame_end = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    shadow_d = bcd_in;
                    idx_d    = '0;
                    cnt_d    = '0;
                    state_d  = AFTER_DIGIT;
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_SHOW;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt == DWELL_LAST) begin
                        cnt_d   = '0;
                        state_d = AFTER_DIGIT;
                        if (idx == IDX_LAST) begin
                            idx_d     = '0;
                            frame_end = 1'b1;
                            shadow_d  = bcd_in;
                            if (bcnt == BLINK_LAST) begin
                                bcnt_d  = '0;
                                phase_d = ~phase;
                            end else begin
                                bcnt_d = bcnt + 1'b1;
                            end
                        end else begin
                            idx_d = idx + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are built from the next-state values so the registered pins
    // line up with the state they describe rather than lagging by a cycle.
    assign show       = (state_d == ST_SHOW);
    assign onehot     = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d;
    assign upper      = shadow_d >> {idx_d, 2'b00};
    assign digit_code = upper[3:0];

    seg7_decode u_decode (
        .code (digit_code),
        .seg  (dec_seg)
    );

    // Blanking rules and active-high output patterns for the selected digit.
    always_comb begin
        lzb_hit   = lzb_en && (idx_d != '0) && (upper == '0);
        blink_hit = phase_d && (|(blink_mask & onehot));
        seg_n     = SEG_BLANK;
        dig_n     = '0;
        if (show) begin
            dig_n = onehot;
            if (!lzb_hit && !blink_hit) begin
                seg_n = dec_seg;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            bcnt       <= '0;
            phase      <= 1'b0;
            seg        <= SEG_OFF;
            dig_sel    <= DIG_OFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            shadow     <= shadow_d;
            bcnt       <= bcnt_d;
            phase      <= phase_d;
            seg        <= seg_n ^ SEG_OFF;
            dig_sel    <= dig_n ^ DIG_OFF;
            frame_done <= frame_end;
        end
    end

`ifdef SEG_SCAN_DP_EN
    logic [N_DIGITS-1:0] dp_shadow, dp_shadow_d;
    logic                dp_n;

    // Decimal points are captured alongside the BCD digits and obey blink only.
    always_comb begin
        dp_shadow_d = dp_shadow;
        if (en && ((state == ST_IDLE) || frame_end)) begin
            dp_shadow_d = dp_in;
        end
        dp_n = show && !blink_hit && (|(dp_shadow_d & onehot));
    end

    // Decimal-point shadow and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_shadow <= '0;
            dp        <= POL;
        end else begin
            dp_shadow <= dp_shadow_d;
            dp        <= dp_n ^ POL;
        end
    end
`endif

endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: scoreboard bench for seg_scan_mux.
// An active-high and an active-low instance share all stimulus; a frame-level
// reference model queues the expected pins each cycle and a monitor compares.
module tb_seg_scan_mux;

    localparam int N  = 4;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam int BF = 2;
    localparam int FL = N * (D + B);

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        lzb_en;
    logic [15:0] bcd_in;
    logic [3:0]  blink_mask;

    logic [6:0]  seg,  seg_al;
    logic [3:0]  dig,  dig_al;
    logic        fd,   fd_al;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .N_DIGITS     (N),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (0)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .blink_mask (blink_mask),
        .lzb_en     (lzb_en),
        .seg        (seg),
        .dig_sel    (dig),
        .frame_done (fd)
    );

    seg_scan_mux #(
        .N_DIGITS     (N),
        .DWELL_CYCLES (D),
        .BLANK_CYCLES (B),
        .BLINK_FRAMES (BF),
        .ACTIVE_LOW   (1)
    ) u_dut_al (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .bcd_in     (bcd_in),
        .blink_mask (blink_mask),
        .lzb_en     (lzb_en),
        .seg        (seg_al),
        .dig_sel    (dig_al),
        .frame_done (fd_al)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    exp_t expq[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    function automatic logic [6:0] ref_seg(input int v);
        case (v)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    // Reference model: position within the frame decides which digit is lit.
    bit   running = 1'b0;
    int   pos     = 0;
    int   frames  = 0;
    int   fbcd    = 0;
    exp_t e_mod;

    task automatic model_step();
        int  slot;
        int  digit;
        bit  blank;
        e_mod = '0;
        if (rst) begin
            running = 1'b0;
            pos     = 0;
            frames  = 0;
        end else if (!en) begin
            running = 1'b0;
        end else begin
            if (!running) begin
                running = 1'b1;
                pos     = 0;
                fbcd    = int'(bcd_in);
            end else begin
                pos++;
                if (pos == FL) begin
                    pos      = 0;
                    frames++;
                    fbcd     = int'(bcd_in);
                    e_mod.fd = 1'b1;
                end
            end
            slot = pos / (D + B);
            if ((pos % (D + B)) >= B) begin
                e_mod.dig = 4'(1 << slot);
                digit     = (fbcd >> (4 * slot)) & 15;
                blank     = lzb_en && (slot > 0);
                for (int d = slot; d < N; d++) begin
                    if (((fbcd >> (4 * d)) & 15) != 0) blank = 1'b0;
                end
                if (((frames / BF) % 2 == 1) && blink_mask[slot]) blank = 1'b1;
                e_mod.seg = blank ? 7'h00 : ref_seg(digit);
            end
        end
        expq.push_back(e_mod);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: one expected entry per clock, compared away from the edge.
    exp_t e_mon;
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() == 0) begin
                n_total++;
                $display("FAIL scoreboard cycle=%0d actual=empty required=entry", cyc);
            end else begin
                e_mon = expq.pop_front();
                check("seg",        {25'b0, seg},    {25'b0, e_mon.seg});
                check("dig_sel",    {28'b0, dig},    {28'b0, e_mon.dig});
                check("frame_done", {31'b0, fd},     {31'b0, e_mon.fd});
                check("seg_al",     {25'b0, seg_al}, {25'b0, ~e_mon.seg});
                check("dig_sel_al", {28'b0, dig_al}, {28'b0, ~e_mon.dig});
                check("frame_done_al", {31'b0, fd_al}, {31'b0, e_mon.fd});
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Advance until a digit is lit, bounded; expiry counts as a failure.
    task automatic wait_show();
        int k;
        k = 0;
        while (dig == 4'b0 && k < 60) begin
            run(1);
            k++;
        end
        if (dig == 4'b0) begin
            n_total++;
            $display("FAIL wait_show cycle=%0d actual=no_digit required=lit_digit", cyc);
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        lzb_en     = 1'b0;
        bcd_in     = 16'h1234;
        blink_mask = 4'b0000;
        run(3);
        rst = 1'b0;
        run(2);

        // Basic scan, then a mid-frame change that must wait for the boundary.
        en = 1'b1;
        run(10);
        bcd_in = 16'h5678;
        run(FL * 2);

        // Leading-zero blanking.
        lzb_en = 1'b1;
        bcd_in = 16'h0070;
        run(FL * 2);
        bcd_in = 16'h0000;
        run(FL * 2);

        // Blink on digits 0 and 1 across several half-periods.
        lzb_en     = 1'b0;
        bcd_in     = 16'h1234;
        blink_mask = 4'b0011;
        run(FL * 6);

        // Invalid code, then en dropped mid-SHOW and restored.
        blink_mask = 4'b0000;
        bcd_in     = 16'hF000;
        run(FL);
        wait_show();
        run(1);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(FL + 5);

        // Reset mid-SHOW with blink active.
        blink_mask = 4'b1111;
        run(FL * 2);
        wait_show();
        run(1);
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        run(FL * 3);

        // Randomized mix of data, masks, enables and occasional resets.
        repeat (40) begin
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 1) == 1) bcd_in = bcd_in & 16'h00FF;
            blink_mask = 4'($urandom);
            lzb_en     = 1'($urandom_range(0, 1));
            en         = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                run(2);
                rst = 1'b0;
            end
            run($urandom_range(1, 3 * FL));
        end
        en = 1'b1;
        run(FL * 2);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
